// File: rtl/sequencer_control_unit_pkg.sv
// ctrl_pkg: shared types and constants for the multi-cycle control sequencer.
//   state_t      - sequencer states
//   OP_*         - opcode values (all-ones is HALT, undefined values are NOP)
//   ALU_OP_*     - ALU select values driven on alu_op
//   WAIT_CNT_W   - width of the memory-wait supervision counter
//   is_alu_class - true for opcodes that go EXECUTE -> WRITEBACK
package ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXECUTE,
    MEM,
    WRITEBACK,
    HALT,
    FAULT
  } state_t;

  localparam int unsigned OP_LOAD  = 0;
  localparam int unsigned OP_STORE = 1;
  localparam int unsigned OP_ADD   = 2;
  localparam int unsigned OP_SUB   = 3;
  localparam int unsigned OP_AND   = 4;
  localparam int unsigned OP_OR    = 5;
  localparam int unsigned OP_JMP   = 6;
  localparam int unsigned OP_JZ    = 7;

  // Highest opcode with a defined meaning; anything above it (other than
  // all-ones) decodes as NOP.
  localparam int unsigned OP_LAST_DEFINED = OP_JZ;

  // ALU ops reuse the opcode value; address computation uses 0 (add).
  localparam int unsigned ALU_OP_ADDR = 0;
  localparam int unsigned ALU_OP_ADD  = OP_ADD;
  localparam int unsigned ALU_OP_SUB  = OP_SUB;
  localparam int unsigned ALU_OP_AND  = OP_AND;
  localparam int unsigned ALU_OP_OR   = OP_OR;

  localparam int unsigned WAIT_CNT_W = 8;

  function automatic logic is_alu_class(input int unsigned op);
    return (op >= OP_ADD) && (op <= OP_OR);
  endfunction

endpackage

// File: rtl/sequencer_control_unit_wait_timer.sv
// wait_timer: counts consecutive cycles spent waiting on mem_ready.
//   clk     - clock
//   rst     - synchronous active-high reset, clears the count
//   clear   - clears the count (used whenever no wait is in progress)
//   enable  - advance the count by one this cycle
//   expired - count has reached WAIT_MAX
module wait_timer
  import ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [WAIT_CNT_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + WAIT_CNT_W'(1);
    end
  end

  assign expired = (count_reg == WAIT_CNT_W'(WAIT_MAX));

endmodule

// File: rtl/sequencer_control_unit.sv
// sequencer_control_unit: multi-cycle FETCH/DECODE/EXECUTE/MEM/WRITEBACK
// control sequencer with a supervised memory handshake.
//   clk, rst   - clock and synchronous active-high reset
//   opcode     - IR opcode field, sampled in DECODE only
//   mem_ready  - memory completed the current access (FETCH/MEM only)
//   zero_flag  - ALU zero flag, consulted by JZ in EXECUTE
//   alu_op     - ALU select (opcode for ALU ops, 0 otherwise)
//   pc_inc     - PC += 1 (FETCH completion)
//   pc_load    - PC <= jump target (JMP, taken JZ)
//   ir_load    - IR captures memory data (FETCH completion)
//   mem_read   - read request (FETCH, LOAD in MEM)
//   mem_write  - write request (STORE in MEM)
//   reg_write  - register file write (WRITEBACK)
//   halted     - high while in HALT
//   fault      - high while in FAULT (memory wait timed out)
// Outputs are combinational from state, op register and inputs, and are
// all forced low while rst is high.
module sequencer_control_unit
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int ALU_OP_W = 4,
  parameter int WAIT_MAX = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  input  logic                zero_flag,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                pc_inc,
  output logic                pc_load,
  output logic                ir_load,
  output logic                mem_read,
  output logic                mem_write,
  output logic                reg_write,
  output logic                halted,
  output logic                fault
);

  state_t              state;
  logic [OPCODE_W-1:0] op_reg;

  // Instruction class of the latched opcode (valid from EXECUTE onward).
  logic op_is_load;
  logic op_is_store;
  logic op_is_jmp;
  logic op_is_jz;
  logic op_is_alu;

  assign op_is_load  = (op_reg == OPCODE_W'(OP_LOAD));
  assign op_is_store = (op_reg == OPCODE_W'(OP_STORE));
  assign op_is_jmp   = (op_reg == OPCODE_W'(OP_JMP));
  assign op_is_jz    = (op_reg == OPCODE_W'(OP_JZ));
  assign op_is_alu   = is_alu_class(32'(op_reg));

  // Classification of the live opcode input, used only in DECODE.
  logic in_is_halt;
  logic in_is_nop;

  assign in_is_halt = &opcode;
  assign in_is_nop  = !in_is_halt && (opcode > OPCODE_W'(OP_LAST_DEFINED));

  // The timer runs only while a memory request is outstanding. Clearing it
  // in every other cycle (and on the completing cycle) guarantees it starts
  // from zero on each entry to FETCH or MEM.
  logic waiting;
  logic timer_clear;
  logic timer_enable;
  logic timer_expired;

  assign waiting      = (state == FETCH) || (state == MEM);
  assign timer_enable = waiting && !mem_ready;
  assign timer_clear  = !waiting || mem_ready;

  wait_timer #(
    .WAIT_MAX(WAIT_MAX)
  ) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .enable (timer_enable),
    .expired(timer_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= FETCH;
      op_reg <= '0;
    end else begin
      case (state)
        FETCH: begin
          // mem_ready takes priority over an expiring timer.
          if (mem_ready) begin
            state <= DECODE;
          end else if (timer_expired) begin
            state <= FAULT;
          end
        end
        DECODE: begin
          op_reg <= opcode;
          if (in_is_halt) begin
            state <= HALT;
          end else if (in_is_nop) begin
            state <= FETCH;
          end else begin
            state <= EXECUTE;
          end
        end
        EXECUTE: begin
          if (op_is_load || op_is_store) begin
            state <= MEM;
          end else if (op_is_jmp || op_is_jz) begin
            state <= FETCH;
          end else begin
            state <= WRITEBACK;
          end
        end
        MEM: begin
          if (mem_ready) begin
            state <= op_is_load ? WRITEBACK : FETCH;
          end else if (timer_expired) begin
            state <= FAULT;
          end
        end
        WRITEBACK: state <= FETCH;
        HALT:      state <= HALT;
        FAULT:     state <= FAULT;
        default:   state <= FETCH;
      endcase
    end
  end

  always_comb begin
    alu_op    = '0;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    ir_load   = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    halted    = 1'b0;
    fault     = 1'b0;
    if (!rst) begin
      case (state)
        FETCH: begin
          mem_read = 1'b1;
          ir_load  = mem_ready;
          pc_inc   = mem_ready;
        end
        EXECUTE: begin
          alu_op  = op_is_alu ? ALU_OP_W'(op_reg) : ALU_OP_W'(ALU_OP_ADDR);
          pc_load = op_is_jmp || (op_is_jz && zero_flag);
        end
        MEM: begin
          // op_reg is either LOAD or STORE here, so these are exclusive.
          mem_read  = op_is_load;
          mem_write = op_is_store;
        end
        WRITEBACK: reg_write = 1'b1;
        HALT:      halted    = 1'b1;
        FAULT:     fault     = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sequencer_control_unit.sv
module tb_sequencer_control_unit;

  localparam int OPCODE_W = 4;
  localparam int ALU_OP_W = 4;
  localparam int WAIT_MAX = 15;

  // Expected output word: {alu_op[11:8], pc_inc, pc_load, ir_load,
  //                        mem_read, mem_write, reg_write, halted, fault}
  localparam logic [11:0] E_NONE = 12'h000;
  localparam logic [11:0] E_PI   = 12'h080;
  localparam logic [11:0] E_PL   = 12'h040;
  localparam logic [11:0] E_IR   = 12'h020;
  localparam logic [11:0] E_MR   = 12'h010;
  localparam logic [11:0] E_MW   = 12'h008;
  localparam logic [11:0] E_RW   = 12'h004;
  localparam logic [11:0] E_H    = 12'h002;
  localparam logic [11:0] E_F    = 12'h001;
  localparam logic [11:0] E_FD   = E_PI | E_IR | E_MR;  // fetch completes

  typedef struct {
    logic        rst;
    logic        mem_ready;
    logic [3:0]  opcode;
    logic        zero_flag;
    logic [11:0] exp;
  } vec_t;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [OPCODE_W-1:0] opcode = '0;
  logic                mem_ready = 1'b0;
  logic                zero_flag = 1'b0;
  logic [ALU_OP_W-1:0] alu_op;
  logic                pc_inc, pc_load, ir_load, mem_read, mem_write;
  logic                reg_write, halted, fault;

  int checks = 0;
  int passed = 0;

  vec_t  tbl[$];
  string tbl_tag[$];
  vec_t  q[$];

  always #5 clk = ~clk;

  sequencer_control_unit #(
    .OPCODE_W(OPCODE_W),
    .ALU_OP_W(ALU_OP_W),
    .WAIT_MAX(WAIT_MAX)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .opcode   (opcode),
    .mem_ready(mem_ready),
    .zero_flag(zero_flag),
    .alu_op   (alu_op),
    .pc_inc   (pc_inc),
    .pc_load  (pc_load),
    .ir_load  (ir_load),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .reg_write(reg_write),
    .halted   (halted),
    .fault    (fault)
  );

  function automatic vec_t mk(input logic r, input logic mr, input logic [3:0] op,
                              input logic z, input logic [11:0] e);
    vec_t v;
    v.rst = r; v.mem_ready = mr; v.opcode = op; v.zero_flag = z; v.exp = e;
    return v;
  endfunction

  // One clock cycle: drive inputs just after the rising edge, compare the
  // combinational outputs at the falling edge.
  task automatic apply(input vec_t v, input string tag);
    logic [11:0] got;
    rst       = v.rst;
    mem_ready = v.mem_ready;
    opcode    = v.opcode;
    zero_flag = v.zero_flag;
    @(negedge clk);
    got = {alu_op, pc_inc, pc_load, ir_load, mem_read, mem_write, reg_write, halted, fault};
    checks++;
    if (got === v.exp) passed++;
    else $display("FAIL %s (check %0d): outputs %03h, expected %03h", tag, checks, got, v.exp);
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input logic r, input logic mr, input logic [3:0] op,
                      input logic z, input logic [11:0] e);
    apply(mk(r, mr, op, z, e), tag);
  endtask

  task automatic tadd(input string tag, input logic r, input logic mr, input logic [3:0] op,
                      input logic z, input logic [11:0] e);
    tbl.push_back(mk(r, mr, op, z, e));
    tbl_tag.push_back(tag);
  endtask

  // ---------------- reference model (instruction -> cycle list) ----------
  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [3:0] rop();
    return 4'($urandom_range(0, 15));
  endfunction

  task automatic push(input logic mr, input logic [3:0] op, input logic z, input logic [11:0] e);
    q.push_back(mk(1'b0, mr, op, z, e));
  endtask

  // Number of not-ready cycles before memory answers; beyond WAIT_MAX it
  // never answers in time.
  function automatic int pick_wait();
    int s;
    s = int'($urandom_range(0, 15));
    if (s < 8)   return 0;
    if (s < 11)  return s - 7;
    if (s < 13)  return int'($urandom_range(4, WAIT_MAX - 2));
    if (s == 13) return WAIT_MAX;
    if (s == 14) return WAIT_MAX - 1;
    return WAIT_MAX + 1;
  endfunction

  // A memory access: the request is held through every not-ready cycle and
  // the completing cycle; WAIT_MAX+1 unanswered cycles lead to a sticky fault.
  task automatic mem_phase(input bit is_fetch, input bit is_write, output bit faulted);
    int w;
    int n;
    logic [11:0] req;
    w       = pick_wait();
    req     = is_write ? E_MW : E_MR;
    faulted = (w > WAIT_MAX);
    n       = faulted ? WAIT_MAX + 1 : w;
    for (int i = 0; i < n; i++) push(1'b0, rop(), rb(), req);
    if (faulted) begin
      for (int i = 0; i < 3; i++) push(rb(), rop(), rb(), E_F);
    end else begin
      push(1'b1, rop(), rb(), is_fetch ? E_FD : req);
    end
  endtask

  task automatic build_instr(input logic [3:0] op, output bit stopped);
    bit   f;
    logic z;
    stopped = 1'b0;
    mem_phase(1'b1, 1'b0, f);
    if (f) begin
      stopped = 1'b1;
      return;
    end
    push(rb(), op, rb(), E_NONE);  // DECODE
    if (op == 4'hF) begin
      for (int i = 0; i < 4; i++) push(rb(), rop(), rb(), E_H);
      stopped = 1'b1;
    end else if (op > 4'd7) begin
      // NOP: back to FETCH straight from DECODE
    end else if (op >= 4'd2 && op <= 4'd5) begin
      push(rb(), rop(), rb(), {op, 8'h00});
      push(rb(), rop(), rb(), E_RW);
    end else if (op == 4'd6) begin
      push(rb(), rop(), rb(), E_PL);
    end else if (op == 4'd7) begin
      z = rb();
      push(rb(), rop(), z, z ? E_PL : E_NONE);
    end else begin
      push(rb(), rop(), rb(), E_NONE);  // address computation, alu_op 0
      mem_phase(1'b0, op == 4'd1, f);
      if (f) stopped = 1'b1;
      else if (op == 4'd0) push(rb(), rop(), rb(), E_RW);
    end
  endtask

  initial begin : main
    bit          stopped;
    logic [3:0]  op;
    int          len;
    int          last;

    // ---------------- table-driven directed vectors --------------------
    tadd("reset",  1, 0, 4'h0, 0, E_NONE);
    tadd("reset",  1, 1, 4'hF, 1, E_NONE);
    // ADD, memory always ready
    tadd("add",    0, 1, 4'hF, 0, E_FD);
    tadd("add",    0, 1, 4'h2, 0, E_NONE);
    tadd("add",    0, 1, 4'hF, 0, 12'h200);
    tadd("add",    0, 1, 4'hF, 0, E_RW);
    // LOAD with three not-ready cycles in MEM
    tadd("load",   0, 1, 4'h3, 0, E_FD);
    tadd("load",   0, 1, 4'h0, 0, E_NONE);
    tadd("load",   0, 1, 4'hF, 0, E_NONE);
    tadd("load",   0, 0, 4'hF, 0, E_MR);
    tadd("load",   0, 0, 4'hF, 0, E_MR);
    tadd("load",   0, 0, 4'hF, 0, E_MR);
    tadd("load",   0, 1, 4'hF, 0, E_MR);
    tadd("load",   0, 0, 4'hF, 0, E_RW);
    // JZ taken then not taken
    tadd("jz1",    0, 1, 4'h0, 0, E_FD);
    tadd("jz1",    0, 1, 4'h7, 0, E_NONE);
    tadd("jz1",    0, 1, 4'h0, 1, E_PL);
    tadd("jz0",    0, 1, 4'h0, 1, E_FD);
    tadd("jz0",    0, 1, 4'h7, 1, E_NONE);
    tadd("jz0",    0, 1, 4'h0, 0, E_NONE);
    // JMP, SUB, AND, OR, STORE, NOP
    tadd("jmp",    0, 1, 4'h0, 0, E_FD);
    tadd("jmp",    0, 0, 4'h6, 0, E_NONE);
    tadd("jmp",    0, 0, 4'h0, 0, E_PL);
    tadd("sub",    0, 1, 4'h0, 0, E_FD);
    tadd("sub",    0, 1, 4'h3, 0, E_NONE);
    tadd("sub",    0, 1, 4'h0, 0, 12'h300);
    tadd("sub",    0, 1, 4'h0, 0, E_RW);
    tadd("and",    0, 1, 4'h0, 0, E_FD);
    tadd("and",    0, 1, 4'h4, 0, E_NONE);
    tadd("and",    0, 1, 4'h0, 0, 12'h400);
    tadd("and",    0, 1, 4'h0, 0, E_RW);
    tadd("or",     0, 1, 4'h0, 0, E_FD);
    tadd("or",     0, 1, 4'h5, 0, E_NONE);
    tadd("or",     0, 1, 4'h0, 0, 12'h500);
    tadd("or",     0, 1, 4'h0, 0, E_RW);
    tadd("store",  0, 1, 4'h0, 0, E_FD);
    tadd("store",  0, 1, 4'h1, 0, E_NONE);
    tadd("store",  0, 1, 4'h0, 0, E_NONE);
    tadd("store",  0, 1, 4'h0, 0, E_MW);
    tadd("nop",    0, 1, 4'h0, 0, E_FD);
    tadd("nop",    0, 1, 4'h9, 0, E_NONE);
    tadd("nop",    0, 0, 4'h0, 0, E_MR);

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], tbl_tag[i]);
    $display("directed table: %0d vectors applied", tbl.size());

    // ---------------- fetch timeout: fault from cycle 17 ----------------
    step("fault_rst", 1, 0, 4'h0, 0, E_NONE);
    for (int c = 1; c <= 16; c++) step("fault_wait", 0, 0, 4'h2, 0, E_MR);
    for (int c = 0; c < 4; c++) step("fault_sticky", 0, 1, 4'h2, 1, E_F);
    $display("fetch timeout sequence done");

    // ---------------- ready exactly at count WAIT_MAX: no fault ---------
    step("edge_rst", 1, 0, 4'h0, 0, E_NONE);
    for (int c = 1; c <= 15; c++) step("edge_wait", 0, 0, 4'h0, 0, E_MR);
    step("edge_ready", 0, 1, 4'h0, 0, E_FD);
    step("edge_decode", 0, 0, 4'h0, 0, E_NONE);  // LOAD
    step("edge_exec", 0, 0, 4'h0, 0, E_NONE);
    for (int c = 1; c <= 15; c++) step("edge_mwait", 0, 0, 4'h0, 0, E_MR);
    step("edge_mready", 0, 1, 4'h0, 0, E_MR);
    step("edge_wb", 0, 0, 4'h0, 0, E_RW);
    $display("timeout boundary sequence done");

    // ---------------- MEM timeout on STORE ------------------------------
    step("mfault", 0, 1, 4'h0, 0, E_FD);
    step("mfault", 0, 0, 4'h1, 0, E_NONE);
    step("mfault", 0, 0, 4'h0, 0, E_NONE);
    for (int c = 1; c <= 16; c++) step("mfault_wait", 0, 0, 4'h0, 0, E_MW);
    for (int c = 0; c < 3; c++) step("mfault_sticky", 0, 1, 4'h0, 0, E_F);
    step("mfault_rst", 1, 0, 4'h0, 0, E_NONE);
    step("mfault_after", 0, 0, 4'h0, 0, E_MR);
    $display("store timeout sequence done");

    // ---------------- HALT ----------------------------------------------
    step("halt", 0, 1, 4'h0, 0, E_FD);
    step("halt", 0, 1, 4'hF, 0, E_NONE);
    for (int c = 0; c < 20; c++) step("halt_hold", 0, rb(), rop(), rb(), E_H);
    step("halt_rst", 1, 0, 4'h0, 0, E_NONE);
    step("halt_after", 0, 0, 4'h0, 0, E_MR);
    step("halt_after", 0, 1, 4'h0, 0, E_FD);
    step("halt_after", 0, 0, 4'h8, 0, E_NONE);
    $display("halt sequence done");

    // ---------------- reset during STORE MEM wait -----------------------
    step("st_rst", 0, 1, 4'h0, 0, E_FD);
    step("st_rst", 0, 0, 4'h1, 0, E_NONE);
    step("st_rst", 0, 0, 4'h0, 0, E_NONE);
    step("st_rst_wait", 0, 0, 4'h0, 0, E_MW);
    step("st_rst_wait", 0, 0, 4'h0, 0, E_MW);
    step("st_rst_pulse", 1, 0, 4'h0, 0, E_NONE);
    step("st_rst_after", 0, 0, 4'h0, 0, E_MR);
    step("st_rst_after", 0, 1, 4'h0, 0, E_FD);
    step("st_rst_after", 0, 0, 4'hA, 0, E_NONE);
    step("st_rst_after", 0, 0, 4'h0, 0, E_MR);
    $display("reset during store sequence done");

    // ---------------- randomized instruction stream ---------------------
    step("rand_rst", 1, 0, 4'h0, 0, E_NONE);
    for (int n = 0; n < 250; n++) begin
      op = rop();
      q.delete();
      build_instr(op, stopped);
      if (stopped) q.push_back(mk(1'b1, rb(), rop(), rb(), E_NONE));
      len  = q.size();
      last = checks;
      foreach (q[i]) apply(q[i], "random");
      $display("random instr %0d: opcode %0h, %0d cycles, %0d checks%s",
               n, op, len, checks - last, stopped ? ", ended by reset" : "");
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
